priority_encoder_8to3_sync: RTL and testbench
=============================================

// Module: priority_encoder_8to3_sync
// PURPOSE
//  Inverse of the 3-to-8 decoder: turns 8 raw button/request lines into a registered 3-bit code.
//  Inputs are synchronised, priority-encoded (highest index wins) and debounced.
//  Emits exactly one single-cycle valid pulse per debounced press.
//  Sits between the front-panel buttons and the alarm-clock mode/set control FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable samples required for press and for release (>=1)
//  CNT_WIDTH        8  debounce counter width; must hold DEBOUNCE_CYCLES
// PORTS
//  clk     input   1  system clock, rising edge
//  reset   input   1  asynchronous, active-high reset
//  enable  input   1  encoder enable; low forces IDLE
//  D       input   8  raw asynchronous request lines, active-high
//  Y       output  3  encoded index of the last accepted request (registered)
//  valid   output  1  one-cycle pulse when Y is updated by a new accepted press
//  held    output  1  high while the accepted request is still being held (PRESSED/RELEASE)
// BEHAVIOUR
//  Reset values: Y=3'b000, valid=0, held=0, state=IDLE, counter=0, sync flops=0.
//  - Sync: D goes through 2 flops (Ds). All logic below uses Ds only.
//  - Priority: code(Ds) = index of the highest set bit; nz = |Ds.
//  - IDLE: if enable & nz, then cand<=code(Ds), cnt<=1, go to DEBOUNCE.
//  - DEBOUNCE:
//    - !nz or code(Ds)!=cand -> IDLE (no valid).
//    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, Y<=cand and valid=1 for 1 cycle.
//      Then go to PRESSED with cnt<=0.
//    - DEBOUNCE_CYCLES=1: IDLE goes straight to PRESSED and issues valid on the same edge.
//  - PRESSED: held=1. Changes in Ds are ignored while nz; a higher-priority bit added is not reported.
//    - !nz -> RELEASE, cnt<=1.
//  - RELEASE: held=1.
//    - nz -> back to PRESSED (bounce, no new valid).
//    - !nz for DEBOUNCE_CYCLES total samples -> IDLE, held=0.
//  - enable low: from any state go to IDLE on the next edge. valid=0, held=0, Y holds its value.
//    - enable low in the same cycle that DEBOUNCE would complete: enable wins, no valid.
//  - Latency: D stable from before edge 0 -> valid high after edge DEBOUNCE_CYCLES+1.
//    Default: after edge 5; 6 edges total.
//  - valid is never high 2 cycles in a row. Y changes only on the edge that raises valid.
//  - Async reset mid-operation: all state cleared immediately. Any pending press is lost, no valid.
//  - Counter saturates; it never wraps.
// TESTING
//  1. Reset, enable=1, D=8'h04 held 20 cycles -> single valid pulse 6 edges after assert, Y=3'b010, held=1.
//  2. D=8'hA1 steady -> Y=3'b111 (bit 7 wins); release D=0 for 4+ cycles -> held=0.
//  3. D=8'h08 for 3 cycles then 0 (glitch shorter than debounce) -> no valid, Y unchanged.
//  4. Press D=8'h02 accepted, then bounce 0/02/0 during release, then 0 x6 -> exactly one valid total.
//  5. Press D=8'h10, add bit7 while PRESSED -> no new valid; release, press 8'h80 -> valid, Y=3'b111.
//  6. enable=0 with D=8'hFF -> no valid. Assert reset mid-DEBOUNCE -> Y=0, valid=0, held=0 immediately.

Source files
------------

// File: rtl/priority_encoder_8to3_sync.sv
// Front-panel request encoder: 2-flop synchroniser, highest-index-wins priority
// encode, press/release debounce, and a one-cycle valid pulse per accepted press.
module priority_encoder_8to3_sync #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] D,
    output logic [2:0] Y,
    output logic       valid,
    output logic       held
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_TARGET = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic [7:0]           d_meta_q;
    logic [7:0]           ds_q;
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           cand_q, cand_d;
    logic [2:0]           y_q, y_d;
    logic                 valid_q, valid_d;

    logic                 nz;
    logic [2:0]           code;
    logic [CNT_WIDTH-1:0] cnt_inc;

    function automatic logic [2:0] top_index(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign nz      = |ds_q;
    assign code    = top_index(ds_q);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        y_d     = y_q;
        valid_d = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (nz) begin
                        cand_d = code;
                        if (DEBOUNCE_CYCLES <= 1) begin
                            y_d     = code;
                            valid_d = 1'b1;
                            state_d = ST_PRESSED;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!nz || code != cand_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= CNT_TARGET) begin
                        y_d     = cand_q;
                        valid_d = 1'b1;
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    // Extra or higher-priority bits are ignored until every line drops.
                    if (!nz) begin
                        if (DEBOUNCE_CYCLES <= 1) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (nz) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc >= CNT_TARGET) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_meta_q <= '0;
            ds_q     <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            d_meta_q <= D;
            ds_q     <= d_meta_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
        end
    end

    assign Y     = y_q;
    assign valid = valid_q;
    assign held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_priority_encoder_8to3_sync.sv
// Bench for priority_encoder_8to3_sync: directed scenarios plus random request
// traffic, all checked each cycle against a run-length reference model.
module tb_priority_encoder_8to3_sync;

    localparam int DC = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] D;
    logic [2:0] Y;
    logic       valid;
    logic       held;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;
    int first_valid = -1;
    int tick_idx = 0;

    // Reference model: sync pipeline plus run lengths of matching/zero samples.
    logic [7:0] meta_m, ds_m;
    logic [2:0] y_m, run_code;
    logic       valid_m, held_m;
    int         run, zrun;

    priority_encoder_8to3_sync #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .D      (D),
        .Y      (Y),
        .valid  (valid),
        .held   (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] highest(input logic [7:0] v);
        int h;
        h = 0;
        for (int i = 0; i < 8; i++) if (v[i]) h = i;
        return 3'(h);
    endfunction

    task automatic model_reset();
        meta_m = '0; ds_m = '0; y_m = '0; run_code = '0;
        valid_m = 1'b0; held_m = 1'b0; run = 0; zrun = 0;
    endtask

    task automatic model_step(input logic [7:0] d, input logic en);
        logic [7:0] s;
        s = ds_m;
        ds_m = meta_m;
        meta_m = d;
        valid_m = 1'b0;
        if (!en) begin
            held_m = 1'b0; run = 0; zrun = 0;
        end else if (!held_m) begin
            if (run > 0) begin
                if (s != 0 && highest(s) == run_code) run++;
                else run = 0;
            end else if (s != 0) begin
                run = 1;
                run_code = highest(s);
            end
            if (run >= DC) begin
                y_m = run_code; valid_m = 1'b1; held_m = 1'b1; run = 0; zrun = 0;
            end
        end else begin
            if (s == 0) zrun++;
            else zrun = 0;
            if (zrun >= DC) begin
                held_m = 1'b0; zrun = 0;
            end
        end
    endtask

    task automatic tick(input logic [7:0] d, input logic en);
        @(negedge clk);
        D = d;
        enable = en;
        @(posedge clk);
        model_step(d, en);
        #1;
        check("Y", 32'(Y), 32'(y_m));
        check("valid", 32'(valid), 32'(valid_m));
        check("held", 32'(held), 32'(held_m));
        if (valid) begin
            vcount++;
            if (first_valid < 0) first_valid = tick_idx;
        end
        tick_idx++;
    endtask

    task automatic start_phase();
        vcount = 0;
        first_valid = -1;
        tick_idx = 0;
    endtask

    task automatic repeat_tick(input logic [7:0] d, input logic en, input int n);
        for (int i = 0; i < n; i++) tick(d, en);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        D = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_Y", 32'(Y), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_held", 32'(held), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: steady press of bit 2, latency and single pulse
        start_phase();
        repeat_tick(8'h04, 1'b1, 20);
        check("t1_first_valid_edge", 32'(first_valid), 32'd5);
        check("t1_valid_count", 32'(vcount), 32'd1);
        check("t1_Y", 32'(Y), 32'd2);
        check("t1_held", 32'(held), 32'd1);
        repeat_tick(8'h00, 1'b1, 8);

        // 2: multiple bits, highest wins; release clears held
        start_phase();
        repeat_tick(8'hA1, 1'b1, 10);
        check("t2_Y", 32'(Y), 32'd7);
        check("t2_valid_count", 32'(vcount), 32'd1);
        repeat_tick(8'h00, 1'b1, 8);
        check("t2_held_after_release", 32'(held), 32'd0);

        // 3: glitch shorter than debounce
        start_phase();
        repeat_tick(8'h08, 1'b1, 3);
        repeat_tick(8'h00, 1'b1, 8);
        check("t3_valid_count", 32'(vcount), 32'd0);
        check("t3_Y_unchanged", 32'(Y), 32'd7);

        // 4: bounce during release yields a single pulse
        start_phase();
        repeat_tick(8'h02, 1'b1, 8);
        tick(8'h00, 1'b1);
        tick(8'h02, 1'b1);
        repeat_tick(8'h00, 1'b1, 8);
        check("t4_valid_count", 32'(vcount), 32'd1);
        check("t4_Y", 32'(Y), 32'd1);
        check("t4_held", 32'(held), 32'd0);

        // 5: higher bit added while pressed is ignored; later press of it is reported
        start_phase();
        repeat_tick(8'h10, 1'b1, 8);
        check("t5_Y_first", 32'(Y), 32'd4);
        repeat_tick(8'h90, 1'b1, 6);
        check("t5_no_new_valid", 32'(vcount), 32'd1);
        check("t5_Y_kept", 32'(Y), 32'd4);
        repeat_tick(8'h00, 1'b1, 8);
        repeat_tick(8'h80, 1'b1, 8);
        check("t5_valid_count", 32'(vcount), 32'd2);
        check("t5_Y_second", 32'(Y), 32'd7);
        repeat_tick(8'h00, 1'b1, 8);

        // enable dropped on the edge that would complete debounce
        start_phase();
        repeat_tick(8'h20, 1'b1, 5);
        tick(8'h20, 1'b0);
        repeat_tick(8'h00, 1'b1, 6);
        check("en_wins_valid_count", 32'(vcount), 32'd0);
        check("en_wins_Y", 32'(Y), 32'd7);

        // 6: disabled encoder ignores requests; async reset mid-debounce
        start_phase();
        repeat_tick(8'hFF, 1'b0, 10);
        check("t6_disabled_valid_count", 32'(vcount), 32'd0);
        check("t6_disabled_held", 32'(held), 32'd0);
        repeat_tick(8'hFF, 1'b1, 3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("t6_async_Y", 32'(Y), 32'd0);
        check("t6_async_valid", 32'(valid), 32'd0);
        check("t6_async_held", 32'(held), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        D = 8'h00;
        start_phase();
        repeat_tick(8'h00, 1'b1, 6);
        check("t6_after_reset_valid_count", 32'(vcount), 32'd0);

        // Random traffic: values held for random durations, occasional disable
        for (int k = 0; k < 60; k++) begin
            logic [7:0] v;
            logic       en;
            int         len;
            v   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            len = $urandom_range(1, 9);
            repeat_tick(v, en, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
